// File: rtl/vslc_timer_pkg.sv
// Shared types and constants for the VSLC multi-channel timer bank.
package vslc_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PHASE_A = 2'd1,
        PHASE_B = 2'd2,
        HOLD    = 2'd3
    } chan_state_t;

    localparam int PRESCALE_W = 8;

endpackage

// File: rtl/vslc_timer_channel.sv
// One two-phase timer channel: state machine, tick counter and period shadows.
// Period inputs are captured only at phase-A entry, so PWM updates never glitch mid-cycle.
module vslc_timer_channel
    import vslc_timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             enable,
    input  logic             oneshot,
    input  logic [WIDTH-1:0] period_a,
    input  logic [WIDTH-1:0] period_b,
    output logic             timer_out,
    output logic             done,
    output logic             busy
);

    chan_state_t      state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] shadow_a;
    logic [WIDTH-1:0] shadow_b;
    logic             end_a;
    logic             end_b;
    logic             latch;

    assign end_a = tick && (cnt == shadow_a);
    assign end_b = tick && (cnt == shadow_b);

    // Shadows reload on arming from IDLE and on every continuous-mode wrap back to phase A.
    assign latch = enable && ((state == IDLE) || (state == PHASE_B && end_b && !oneshot));

    assign busy = (state == PHASE_A) || (state == PHASE_B);

    // Channel FSM with registered waveform and done pulse; disable wins over any tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            timer_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                cnt       <= '0;
                timer_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= PHASE_A;
                        cnt       <= '0;
                        timer_out <= 1'b0;
                    end
                    PHASE_A: begin
                        if (end_a) begin
                            state     <= PHASE_B;
                            cnt       <= '0;
                            timer_out <= 1'b1;
                        end else if (tick) begin
                            cnt <= cnt + WIDTH'(1);
                        end
                    end
                    PHASE_B: begin
                        if (end_b) begin
                            timer_out <= 1'b0;
                            done      <= 1'b1;
                            cnt       <= '0;
                            state     <= oneshot ? HOLD : PHASE_A;
                        end else if (tick) begin
                            cnt <= cnt + WIDTH'(1);
                        end
                    end
                    HOLD: begin
                        timer_out <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Period shadow capture; pure data, so no reset is needed.
    always_ff @(posedge clk) begin
        if (latch) begin
            shadow_a <= period_a;
            shadow_b <= period_b;
        end
    end

endmodule

// File: rtl/vslc_multi_timer.sv
// VSLC timer bank: shared timer_clk edge detector, optional tick prescaler and
// CHANNELS independent two-phase timer channels.
// Optional feature macro: VSLC_TIMER_PRESCALE_EN adds the prescale port and an
// 8-bit edge divider; without it every timer_clk rising edge is a tick.
module vslc_multi_timer
    import vslc_timer_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      timer_clk,
    input  logic [CHANNELS*WIDTH-1:0] period_a,
    input  logic [CHANNELS*WIDTH-1:0] period_b,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       oneshot,
`ifdef VSLC_TIMER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0]     prescale,
`endif
    output logic [CHANNELS-1:0]       timer_out,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       busy
);

    logic tick_prev;
    logic tick;
    logic raw_edge;
    logic tick_fire;

    assign raw_edge = timer_clk & ~tick_prev;

`ifdef VSLC_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] div_cnt;
    logic                  div_hit;

    // >= keeps the divider from running the full 8-bit range if prescale shrinks mid-count.
    assign div_hit   = (div_cnt >= prescale);
    assign tick_fire = raw_edge & div_hit;

    // Shared edge divider; idles at 0 whenever no channel is enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (enable == '0) begin
            div_cnt <= '0;
        end else if (raw_edge) begin
            div_cnt <= div_hit ? '0 : div_cnt + PRESCALE_W'(1);
        end
    end
`else
    assign tick_fire = raw_edge;
`endif

    // Edge detector and registered tick; tick_prev resets high so a high timer_clk at release is not a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_prev <= 1'b1;
            tick      <= 1'b0;
        end else begin
            tick_prev <= timer_clk;
            tick      <= tick_fire;
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
        vslc_timer_channel #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .enable    (enable[n]),
            .oneshot   (oneshot[n]),
            .period_a  (period_a[n*WIDTH +: WIDTH]),
            .period_b  (period_b[n*WIDTH +: WIDTH]),
            .timer_out (timer_out[n]),
            .done      (done[n]),
            .busy      (busy[n])
        );
    end

endmodule

// File: tb/tb_vslc_multi_timer.sv
// Self-checking bench for vslc_multi_timer: a position-in-cycle model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_vslc_multi_timer;

    localparam int CH = 4;
    localparam int W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              timer_clk = 1'b0;
    logic [CH*W-1:0]   period_a = '0;
    logic [CH*W-1:0]   period_b = '0;
    logic [CH-1:0]     enable = '0;
    logic [CH-1:0]     oneshot = '0;
`ifdef VSLC_TIMER_PRESCALE_EN
    logic [7:0]        prescale = 8'd0;
`endif
    logic [CH-1:0]     timer_out;
    logic [CH-1:0]     done;
    logic [CH-1:0]     busy;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    logic [CH-1:0] s_out, s_done, s_busy;

    always #5 clk = ~clk;

    vslc_multi_timer #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .timer_clk (timer_clk),
        .period_a  (period_a),
        .period_b  (period_b),
        .enable    (enable),
        .oneshot   (oneshot),
`ifdef VSLC_TIMER_PRESCALE_EN
        .prescale  (prescale),
`endif
        .timer_out (timer_out),
        .done      (done),
        .busy      (busy)
    );

    // Model: each running channel tracks ticks since phase-A start; output high once
    // that count reaches len_a, cycle completes at len_a+len_b.
    int m_mode [CH];   // 0 idle, 1 running, 2 holding
    int m_pos  [CH];
    int m_la   [CH];
    int m_lb   [CH];
    logic [CH-1:0] m_out, m_done, m_busy;
    logic m_prev;
    logic m_tick;
    int   m_div;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev = 1'b1;
            m_tick = 1'b0;
            m_div  = 0;
            m_out  = '0;
            m_done = '0;
            m_busy = '0;
            for (int c = 0; c < CH; c++) begin
                m_mode[c] = 0;
                m_pos[c]  = 0;
                m_la[c]   = 1;
                m_lb[c]   = 1;
            end
        end else begin
            logic t_now;
            logic edge_s;
            t_now  = m_tick;
            edge_s = timer_clk && !m_prev;
            m_prev = timer_clk;
`ifdef VSLC_TIMER_PRESCALE_EN
            m_tick = edge_s && (m_div >= int'(prescale));
            if (enable == '0) m_div = 0;
            else if (edge_s) m_div = (m_div >= int'(prescale)) ? 0 : m_div + 1;
`else
            m_tick = edge_s;
`endif
            for (int c = 0; c < CH; c++) begin
                m_done[c] = 1'b0;
                if (!enable[c]) begin
                    m_mode[c] = 0;
                    m_pos[c]  = 0;
                end else if (m_mode[c] == 0) begin
                    m_mode[c] = 1;
                    m_pos[c]  = 0;
                    m_la[c]   = int'(period_a[c*W +: W]) + 1;
                    m_lb[c]   = int'(period_b[c*W +: W]) + 1;
                end else if (m_mode[c] == 1 && t_now) begin
                    m_pos[c] = m_pos[c] + 1;
                    if (m_pos[c] == m_la[c] + m_lb[c]) begin
                        m_done[c] = 1'b1;
                        m_pos[c]  = 0;
                        if (oneshot[c]) begin
                            m_mode[c] = 2;
                        end else begin
                            m_la[c] = int'(period_a[c*W +: W]) + 1;
                            m_lb[c] = int'(period_b[c*W +: W]) + 1;
                        end
                    end
                end
                m_out[c]  = (m_mode[c] == 1) && (m_pos[c] >= m_la[c]);
                m_busy[c] = (m_mode[c] == 1);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("model_timer_out", 32'(timer_out), 32'(m_out));
            chk("model_done",      32'(done),      32'(m_done));
            chk("model_busy",      32'(busy),      32'(m_busy));
        end
    end

    // One timer_clk pulse; outputs are sampled right after the resulting state update.
    task automatic do_tick();
        timer_clk = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        s_out  = timer_out;
        s_done = done;
        s_busy = busy;
        timer_clk = 1'b0;
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic settle();
        enable  = '0;
        oneshot = '0;
        timer_clk = 1'b0;
        repeat (3) @(posedge clk);
        #2;
    endtask

    bit exp1 [10] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
`ifdef VSLC_TIMER_PRESCALE_EN
    bit exp6 [8]  = '{0, 0, 0, 1, 1, 1, 1, 0};
`endif

    initial begin
        logic act;
        #1 rst = 1'b1;
        started = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_timer_out", 32'(timer_out), 32'h0);
        chk("reset_done",      32'(done),      32'h0);
        chk("reset_busy",      32'(busy),      32'h0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Continuous ch0, 3 ticks low then 2 ticks high.
        period_a[0 +: W] = 16'd2;
        period_b[0 +: W] = 16'd1;
        enable = 4'b0001;
        repeat (2) @(posedge clk);
        #2;
        chk("s1_busy_armed", 32'(busy[0]), 32'h1);
        for (int k = 0; k < 10; k++) begin
            do_tick();
            chk("s1_out",  32'(s_out[0]),  32'(exp1[k]));
            chk("s1_done", 32'(s_done[0]), 32'((k == 4) || (k == 9)));
        end

        // One-shot ch1 with single-tick phases.
        settle();
        period_a[W +: W] = 16'd0;
        period_b[W +: W] = 16'd0;
        oneshot = 4'b0010;
        enable  = 4'b0010;
        repeat (2) @(posedge clk);
        #2;
        do_tick();
        chk("s2_out_b",   32'(s_out[1]),  32'h1);
        chk("s2_busy_b",  32'(s_busy[1]), 32'h1);
        do_tick();
        chk("s2_out_end", 32'(s_out[1]),  32'h0);
        chk("s2_done",    32'(s_done[1]), 32'h1);
        chk("s2_hold",    32'(s_busy[1]), 32'h0);
        act = 1'b0;
        for (int k = 0; k < 20; k++) begin
            do_tick();
            act = act | s_out[1] | s_done[1] | s_busy[1];
        end
        chk("s2_quiet", 32'(act), 32'h0);
        enable[1] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        enable[1] = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        do_tick();
        chk("s2_rearm_out",  32'(s_out[1]),  32'h1);
        do_tick();
        chk("s2_rearm_done", 32'(s_done[1]), 32'h1);

        // Period change mid phase A takes effect at the next A.
        settle();
        period_a[2*W +: W] = 16'd5;
        period_b[2*W +: W] = 16'd0;
        enable = 4'b0100;
        repeat (2) @(posedge clk);
        #2;
        do_tick();
        do_tick();
        period_a[2*W +: W] = 16'd1;
        for (int k = 3; k <= 9; k++) begin
            do_tick();
            chk("s3_out",  32'(s_out[2]),  32'((k == 6) || (k == 9)));
            chk("s3_done", 32'(s_done[2]), 32'(k == 7));
        end

        // Disable coincident with the terminal tick of phase B.
        settle();
        period_a[0 +: W] = 16'd0;
        period_b[0 +: W] = 16'd0;
        enable = 4'b0001;
        repeat (2) @(posedge clk);
        #2;
        do_tick();
        chk("s4_in_b", 32'(s_out[0]), 32'h1);
        timer_clk = 1'b1;
        @(posedge clk);
        #2;
        enable[0] = 1'b0;
        @(posedge clk);
        #2;
        chk("s4_no_done", 32'(done[0]),      32'h0);
        chk("s4_out",     32'(timer_out[0]), 32'h0);
        chk("s4_idle",    32'(busy[0]),      32'h0);
        timer_clk = 1'b0;
        repeat (2) @(posedge clk);
        #2;

        // Async reset mid phase B with timer_clk held high.
        settle();
        period_a[0 +: W] = 16'd0;
        period_b[0 +: W] = 16'd3;
        enable = 4'b0001;
        repeat (2) @(posedge clk);
        #2;
        do_tick();
        timer_clk = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("s5_pre_out",  32'(timer_out[0]), 32'h1);
        chk("s5_pre_busy", 32'(busy[0]),      32'h1);
        rst = 1'b1;
        #1;
        chk("s5_async_out",  32'(timer_out), 32'h0);
        chk("s5_async_busy", 32'(busy),      32'h0);
        chk("s5_async_done", 32'(done),      32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("s5_rearmed",  32'(busy[0]),      32'h1);
        chk("s5_no_tick",  32'(timer_out[0]), 32'h0);
        timer_clk = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        do_tick();
        chk("s5_first_tick", 32'(s_out[0]), 32'h1);

`ifdef VSLC_TIMER_PRESCALE_EN
        // Divide-by-4 ticks.
        settle();
        prescale = 8'd3;
        period_a[3*W +: W] = 16'd0;
        period_b[3*W +: W] = 16'd0;
        enable = 4'b1000;
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 8; k++) begin
            do_tick();
            chk("s6_out",  32'(s_out[3]),  32'(exp6[k]));
            chk("s6_done", 32'(s_done[3]), 32'(k == 7));
        end
        settle();
        prescale = 8'd0;
        period_a[0 +: W] = 16'd2;
        period_b[0 +: W] = 16'd1;
        enable = 4'b0001;
        repeat (2) @(posedge clk);
        #2;
        for (int k = 0; k < 5; k++) begin
            do_tick();
            chk("s6_p0_out",  32'(s_out[0]),  32'(exp1[k]));
            chk("s6_p0_done", 32'(s_done[0]), 32'(k == 4));
        end
`endif

        settle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
